// File: rtl/gpr_wb_arb_pkg.sv
// rtl/gpr_wb_arb_pkg.sv - shared register-file bus types and polarity constants
package gpr_wb_arb_pkg;

  localparam int REG_NUM = 32;

  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] WordDataBus;

  localparam logic ENABLE_N     = 1'b0;
  localparam logic DISABLE_N    = 1'b1;
  localparam logic RESET_ENABLE = 1'b1;

endpackage

// File: rtl/gpr_wb_arb_if.sv
// rtl/gpr_wb_arb_if.sv - write-back arbiter bus: pipeline, long-latency, scoreboard and GPR write port
interface gpr_wb_arb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              pipe_we_n;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] chk_addr_0;
  logic [ADDR_W-1:0] chk_addr_1;
  logic              chk_busy_0;
  logic              chk_busy_1;
  logic              stall_req;
  logic              gpr_we_n;
  logic [ADDR_W-1:0] gpr_wr_addr;
  logic [DATA_W-1:0] gpr_wr_data;

  modport master (
    output pipe_we_n, pipe_addr, pipe_data,
    output lu_valid, lu_addr, lu_data,
    output issue_en, issue_addr, chk_addr_0, chk_addr_1,
    input  lu_ready, chk_busy_0, chk_busy_1, stall_req,
    input  gpr_we_n, gpr_wr_addr, gpr_wr_data
  );

  modport slave (
    input  pipe_we_n, pipe_addr, pipe_data,
    input  lu_valid, lu_addr, lu_data,
    input  issue_en, issue_addr, chk_addr_0, chk_addr_1,
    output lu_ready, chk_busy_0, chk_busy_1, stall_req,
    output gpr_we_n, gpr_wr_addr, gpr_wr_data
  );
endinterface

// File: rtl/gpr_wb_fifo.sv
// rtl/gpr_wb_fifo.sv - synchronous FIFO for buffered long-latency results
module gpr_wb_fifo
  import gpr_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (reset == RESET_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && (reset != RESET_ENABLE)) mem[wr_ptr[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gpr_wb_arb.sv
// rtl/gpr_wb_arb.sv - GPR write-port arbiter with long-latency FIFO and pending scoreboard; option GPR_WB_R0_ZERO_EN
module gpr_wb_arb #(
  parameter int REG_NUM    = gpr_wb_arb_pkg::REG_NUM,
  parameter int ADDR_W     = $bits(gpr_wb_arb_pkg::RegAddrBus),
  parameter int DATA_W     = $bits(gpr_wb_arb_pkg::WordDataBus),
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 4
) (
  input logic         clk,
  input logic         reset,
  gpr_wb_arb_if.slave bus
);
  import gpr_wb_arb_pkg::*;

  localparam int CW = $clog2(STARVE_LIM + 1);
`ifdef GPR_WB_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic              fifo_full, fifo_empty;
  logic              pipe_win, push, pop, issue_set;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              stall_q;
  logic              we_n_q, we_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign pipe_win     = (bus.pipe_we_n == ENABLE_N);
  assign bus.lu_ready = (reset != RESET_ENABLE) && !fifo_full;
  assign push         = bus.lu_valid && bus.lu_ready;
  assign pop          = !pipe_win && !fifo_empty;
  assign issue_set    = bus.issue_en && !(R0_ZERO && bus.issue_addr == '0);

  gpr_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data ({bus.lu_addr, bus.lu_data}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      ({head_addr, head_data})
  );

  // Issue is applied after the pop clear so a same-address re-issue stays pending.
  always_comb begin
    busy_d = busy_q;
    if (pop)       busy_d[head_addr]      = 1'b0;
    if (issue_set) busy_d[bus.issue_addr] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fifo_empty || pop)                        cnt_d = '0;
    else if (pipe_win && cnt_q < CW'(STARVE_LIM)) cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    we_n_d = DISABLE_N;
    addr_d = addr_q;
    data_d = data_q;
    if (pipe_win) begin
      we_n_d = (R0_ZERO && bus.pipe_addr == '0) ? DISABLE_N : ENABLE_N;
      addr_d = bus.pipe_addr;
      data_d = bus.pipe_data;
    end else if (pop) begin
      we_n_d = (R0_ZERO && head_addr == '0) ? DISABLE_N : ENABLE_N;
      addr_d = head_addr;
      data_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ENABLE) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      we_n_q  <= DISABLE_N;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stall_q <= (cnt_d >= CW'(STARVE_LIM));
      we_n_q  <= we_n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.chk_busy_0  = busy_q[bus.chk_addr_0];
  assign bus.chk_busy_1  = busy_q[bus.chk_addr_1];
  assign bus.stall_req   = stall_q;
  assign bus.gpr_we_n    = we_n_q;
  assign bus.gpr_wr_addr = addr_q;
  assign bus.gpr_wr_data = data_q;

endmodule
